// File: rtl/s713_bist_ctrl_if.sv
// Tester-side signal bundle of the s713 BIST controller: test control, status,
// signature readout and the pattern/response paths to the s713 instance.
interface s713_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [34:0] seed;
    logic [22:0] dut_po;
    logic [34:0] dut_pi;
    logic        dut_cken;
    logic        busy;
    logic        done;
    logic [22:0] sig;
    logic        pass;

    modport master (
        output start, abort, seed, dut_po,
        input  dut_pi, dut_cken, busy, done, sig, pass
    );

    modport slave (
        input  start, abort, seed, dut_po,
        output dut_pi, dut_cken, busy, done, sig, pass
    );
endinterface

// File: rtl/s713_bist_ctrl.sv
// BIST sequencer for s713: zero-input flush, LFSR pattern run, 23-bit MISR
// compaction of the primary outputs and comparison against a golden signature.
module s713_bist_ctrl #(
    parameter int unsigned NPAT     = 256,
    parameter int unsigned INIT_CYC = 4,
    parameter logic [22:0] GOLDEN   = 23'h000000
) (
    input  logic             ck,
    input  logic             rn,
    s713_bist_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
    localparam logic [15:0] RUN_LAST  = 16'(NPAT - 1);

    state_t      state, state_nxt;
    logic [34:0] lfsr,  lfsr_nxt;
    logic [22:0] misr,  misr_nxt;
    logic [15:0] cnt,   cnt_nxt;

    // NOTE: combinational blocks use blocking '=' and assign every target a
    // default first; otherwise a path that skips an assignment infers a latch.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        misr_nxt  = misr;
        cnt_nxt   = cnt;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_nxt = S_INIT;
                        lfsr_nxt  = (bus.seed == '0) ? 35'h1 : bus.seed;
                        misr_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end
                S_INIT: begin
                    if (cnt == INIT_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    // The vector on dut_pi this cycle and its settled response
                    // are absorbed on the same edge.
                    lfsr_nxt = {lfsr[33:0], lfsr[34] ^ lfsr[32]};
                    misr_nxt = {misr[21:0], misr[22] ^ misr[17]} ^ bus.dut_po;
                    cnt_nxt  = cnt + 16'd1;
                    if (cnt == RUN_LAST) state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; the async clear covers all of it, there is no memory here.
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            state <= S_IDLE;
            lfsr  <= 35'h1;
            misr  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr_nxt;
            misr  <= misr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // All outputs decode registered state only.
    assign bus.dut_pi   = (state == S_RUN) ? lfsr : '0;
    assign bus.dut_cken = (state == S_INIT) || (state == S_RUN);
    assign bus.busy     = (state == S_INIT) || (state == S_RUN);
    assign bus.done     = (state == S_DONE);
    assign bus.sig      = misr;
    assign bus.pass     = (state == S_DONE) && (misr == GOLDEN);

endmodule

// File: tb/tb_s713_bist_ctrl.sv
// Directed + randomized bench for s713_bist_ctrl; a stand-in combinational
// response function replaces the real s713 for the long signature runs.
module tb_s713_bist_ctrl;

    logic ck = 1'b0;
    logic rn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 ck = ~ck;

    s713_bist_ctrl_if bus_a ();
    s713_bist_ctrl_if bus_b ();
    s713_bist_ctrl_if bus_c ();

    s713_bist_ctrl #(.NPAT(4), .INIT_CYC(2), .GOLDEN(23'h000000)) u_a (
        .ck(ck), .rn(rn), .bus(bus_a.slave));
    s713_bist_ctrl #(.NPAT(4), .INIT_CYC(2), .GOLDEN(23'h00000F)) u_b (
        .ck(ck), .rn(rn), .bus(bus_b.slave));
    s713_bist_ctrl #(.NPAT(256), .INIT_CYC(4), .GOLDEN(23'h000000)) u_c (
        .ck(ck), .rn(rn), .bus(bus_c.slave));

    // u_b mirrors u_a's stimulus and differs only in its golden value.
    assign bus_b.start  = bus_a.start;
    assign bus_b.abort  = bus_a.abort;
    assign bus_b.seed   = bus_a.seed;
    assign bus_b.dut_po = bus_a.dut_po;

    function automatic logic [22:0] fake_po(input logic [34:0] pi);
        return pi[22:0] ^ {pi[34:23], pi[10:0]} ^ {pi[5:0], pi[34:18]} ^ 23'h2A5C3;
    endfunction

    assign bus_c.dut_po = fake_po(bus_c.dut_pi);

    // Reference: pattern k is seed * x^k over the x^35+x^33+1 field (shift-left form).
    function automatic logic [34:0] next_vec(input logic [34:0] v);
        logic [35:0] w;
        w = {v, 1'b0};
        if (w[35]) w = w ^ 36'h1;
        if (v[32]) w = w ^ 36'h1;
        return w[34:0];
    endfunction

    function automatic logic [22:0] model_sig(input logic [34:0] seed, input int n,
                                              input bit use_fake, input logic [22:0] po_const);
        logic [34:0] vecs[$];
        logic [34:0] v;
        logic [23:0] m;
        v = (seed == '0) ? 35'h1 : seed;
        for (int i = 0; i < n; i++) begin
            vecs.push_back(v);
            v = next_vec(v);
        end
        m = '0;
        foreach (vecs[i]) begin
            m = m << 1;
            m[0] = m[23] ^ m[18];
            m[22:0] = m[22:0] ^ (use_fake ? fake_po(vecs[i]) : po_const);
        end
        return m[22:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic run_small(input string tag, input logic [34:0] seed,
                             input logic [22:0] po, input bit hold_start);
        logic [34:0] v;
        logic [22:0] exp_sig;
        bus_a.seed   = seed;
        bus_a.dut_po = po;
        bus_a.start  = 1'b1;
        step();
        if (!hold_start) bus_a.start = 1'b0;
        v = (seed == '0) ? 35'h1 : seed;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_init%0d_pi", tag, i), bus_a.dut_pi, '0);
            check($sformatf("%s_init%0d_cken", tag, i), bus_a.dut_cken, 1'b1);
            check($sformatf("%s_init%0d_busy", tag, i), bus_a.busy, 1'b1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_run%0d_pi", tag, i), bus_a.dut_pi, v);
            check($sformatf("%s_run%0d_done", tag, i), bus_a.done, 1'b0);
            v = next_vec(v);
            step();
        end
        exp_sig = model_sig(seed, 4, 1'b0, po);
        check({tag, "_done"}, bus_a.done, 1'b1);
        check({tag, "_busy"}, bus_a.busy, 1'b0);
        check({tag, "_cken"}, bus_a.dut_cken, 1'b0);
        check({tag, "_pi0"}, bus_a.dut_pi, '0);
        check({tag, "_sig"}, bus_a.sig, exp_sig);
        check({tag, "_pass_a"}, bus_a.pass, exp_sig == 23'h0);
        check({tag, "_pass_b"}, bus_b.pass, exp_sig == 23'hF);
        bus_a.start = 1'b0;
    endtask

    task automatic run_big(input string tag, input logic [34:0] seed, output logic [22:0] got);
        logic [34:0] v;
        int          bad;
        bus_c.seed  = seed;
        bus_c.start = 1'b1;
        step();
        bus_c.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_init%0d_pi", tag, i), bus_c.dut_pi, '0);
            step();
        end
        v   = (seed == '0) ? 35'h1 : seed;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (bus_c.dut_pi !== v && bad < 4) begin
                bad++;
                check($sformatf("%s_vec%0d", tag, i), bus_c.dut_pi, v);
            end
            v = next_vec(v);
            step();
        end
        check({tag, "_vec_all"}, 64'(bad), 64'd0);
        check({tag, "_done"}, bus_c.done, 1'b1);
        check({tag, "_sig"}, bus_c.sig, model_sig(seed, 256, 1'b1, '0));
        got = bus_c.sig;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [34:0] rseed;
        logic [22:0] rpo, exp_part, sig1, sig2;

        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.seed = '0; bus_a.dut_po = '0;
        bus_c.start = 1'b0; bus_c.abort = 1'b0; bus_c.seed = '0;

        #2;
        check("rst_pi", bus_a.dut_pi, '0);
        check("rst_sig", bus_a.sig, '0);
        check("rst_cken", bus_a.dut_cken, 1'b0);
        check("rst_busy", bus_a.busy, 1'b0);
        check("rst_done", bus_a.done, 1'b0);
        check("rst_pass", bus_a.pass, 1'b0);
        @(posedge ck); #1 rn = 1'b1;
        step();
        check("idle_busy", bus_a.busy, 1'b0);

        run_small("po0", 35'h1, 23'h0, 1'b0);
        run_small("po1", 35'h1, 23'h1, 1'b0);
        check("po1_sig_is_f", bus_a.sig, 23'h00000F);
        step(); step();
        check("done_hold", bus_a.done, 1'b1);
        check("sig_hold", bus_a.sig, 23'h00000F);

        run_small("seed0", 35'h0, 23'h1, 1'b1);

        // Abort on the second RUN cycle, with START raised alongside it.
        r = {$urandom, $urandom}; rseed = r[34:0];
        r = {$urandom, $urandom}; rpo = r[22:0];
        bus_a.seed = rseed; bus_a.dut_po = rpo; bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        step(); step(); step();
        bus_a.abort = 1'b1; bus_a.start = 1'b1;
        step();
        bus_a.abort = 1'b0; bus_a.start = 1'b0;
        exp_part = model_sig(rseed, 1, 1'b0, rpo);
        check("abort_cken", bus_a.dut_cken, 1'b0);
        check("abort_busy", bus_a.busy, 1'b0);
        check("abort_pi", bus_a.dut_pi, '0);
        check("abort_sig", bus_a.sig, exp_part);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_nodone%0d", i), bus_a.done, 1'b0);
            step();
        end
        run_small("rerun", rseed, rpo, 1'b0);

        // Asynchronous reset in the middle of RUN.
        r = {$urandom, $urandom}; bus_a.seed = r[34:0]; bus_a.dut_po = 23'h5;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        step(); step(); step();
        #2 rn = 1'b0;
        #1;
        check("arst_pi", bus_a.dut_pi, '0);
        check("arst_sig", bus_a.sig, '0);
        check("arst_cken", bus_a.dut_cken, 1'b0);
        check("arst_busy", bus_a.busy, 1'b0);
        check("arst_done", bus_a.done, 1'b0);
        @(posedge ck); #1 rn = 1'b1;
        step();
        check("arst_idle", bus_a.busy, 1'b0);

        run_big("gold", 35'h5A5A5A5A5, sig1);
        run_big("gold_rerun", 35'h5A5A5A5A5, sig2);
        check("gold_repeat", sig2, model_sig(35'h5A5A5A5A5, 256, 1'b1, '0));
        r = {$urandom, $urandom};
        run_big("rand", r[34:0], sig1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
